// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port-style RAM (fetch A, data B).
// Optional exclusive-hold locking is built when ARB_LOCK_EN is defined.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iReqA,
  input  logic                  iReqB,
  input  logic                  iWeA,
  input  logic                  iWeB,
  input  logic [ADDR_WIDTH-1:0] iAddrA,
  input  logic [ADDR_WIDTH-1:0] iAddrB,
  input  logic [DATA_WIDTH-1:0] iDataA,
  input  logic [DATA_WIDTH-1:0] iDataB,
`ifdef ARB_LOCK_EN
  input  logic                  iLockA,
  input  logic                  iLockB,
`endif
  output logic                  oGntA,
  output logic                  oGntB,
  output logic                  oValidA,
  output logic                  oValidB,
  output logic [DATA_WIDTH-1:0] oRdData,
  output logic                  oRamWriteEnable,
  output logic [ADDR_WIDTH-1:0] oRamReadAddress,
  output logic [ADDR_WIDTH-1:0] oRamWriteAddress,
  output logic [DATA_WIDTH-1:0] oRamDataIn,
  input  logic [DATA_WIDTH-1:0] iRamDataOut
);

  // 1 = B was granted most recently, so A wins the next tie
  logic last_b;

  logic rr_a;
  logic rr_b;
  logic gnt_a;
  logic gnt_b;

  logic sel_we;
  logic rd_go;
  logic wr_go;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

`ifdef ARB_LOCK_EN
  typedef enum logic [1:0] {
    IDLE,
    LOCK_A,
    LOCK_B
  } lock_t;

  lock_t state;
`endif

  // round-robin choice: a lone requester wins, a tie goes to the other side
  always_comb begin
    rr_a = iReqA & (~iReqB | last_b);
    rr_b = iReqB & (~iReqA | ~last_b);
  end

  // final grant: masked by reset, restricted to the owner while locked
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (Reset) begin
`ifdef ARB_LOCK_EN
      unique case (state)
        LOCK_A: gnt_a = iReqA;
        LOCK_B: gnt_b = iReqB;
        default: begin
          gnt_a = rr_a;
          gnt_b = rr_b;
        end
      endcase
`else
      gnt_a = rr_a;
      gnt_b = rr_b;
`endif
    end
  end

  // steer the granted requester's command onto the RAM side
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = iAddrB;
    sel_data = iDataB;
    if (gnt_a) begin
      sel_we   = iWeA;
      sel_addr = iAddrA;
      sel_data = iDataA;
    end else if (gnt_b) begin
      sel_we = iWeB;
    end
    wr_go = (gnt_a | gnt_b) & sel_we;
    rd_go = (gnt_a | gnt_b) & ~sel_we;
  end

  // RAM ports: live command on a grant, otherwise the held values
  always_comb begin
    oGntA            = gnt_a;
    oGntB            = gnt_b;
    oRamWriteEnable  = wr_go;
    oRamReadAddress  = rd_go ? sel_addr : rd_addr_q;
    oRamWriteAddress = wr_go ? sel_addr : wr_addr_q;
    oRamDataIn       = wr_go ? sel_data : wr_data_q;
    oRdData          = iRamDataOut;
  end

  // last-grant pointer moves only when something is granted
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      last_b <= 1'b1;
    end else if (gnt_a) begin
      last_b <= 1'b0;
    end else if (gnt_b) begin
      last_b <= 1'b1;
    end
  end

  // read valid follows a granted read by exactly one cycle
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oValidA <= 1'b0;
      oValidB <= 1'b0;
    end else begin
      oValidA <= gnt_a & ~iWeA;
      oValidB <= gnt_b & ~iWeB;
    end
  end

  // hold registers so idle cycles keep the last RAM address/data
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (rd_go) begin
        rd_addr_q <= sel_addr;
      end
      if (wr_go) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
      end
    end
  end

`ifdef ARB_LOCK_EN
  // lock FSM: enter on a locked grant, leave on unlocked grant or dropped request
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      unique case (state)
        LOCK_A: begin
          if (!iReqA || (gnt_a && !iLockA)) begin
            state <= IDLE;
          end
        end
        LOCK_B: begin
          if (!iReqB || (gnt_b && !iLockB)) begin
            state <= IDLE;
          end
        end
        default: begin
          if (gnt_a && iLockA) begin
            state <= LOCK_A;
          end else if (gnt_b && iLockB) begin
            state <= LOCK_B;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios then random traffic,
// checked against a transaction-level model of the arbitration rules.
module tb_ram_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          reqA, reqB, weA, weB;
  logic [AW-1:0] addrA, addrB;
  logic [DW-1:0] dataA, dataB;
`ifdef ARB_LOCK_EN
  logic          lockA, lockB;
`endif

  logic          oGntA, oGntB, oValidA, oValidB, oRamWriteEnable;
  logic [DW-1:0] oRdData, oRamDataIn, ram_q;
  logic [AW-1:0] oRamReadAddress, oRamWriteAddress;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .iReqA(reqA),
    .iReqB(reqB),
    .iWeA(weA),
    .iWeB(weB),
    .iAddrA(addrA),
    .iAddrB(addrB),
    .iDataA(dataA),
    .iDataB(dataB),
`ifdef ARB_LOCK_EN
    .iLockA(lockA),
    .iLockB(lockB),
`endif
    .oGntA(oGntA),
    .oGntB(oGntB),
    .oValidA(oValidA),
    .oValidB(oValidB),
    .oRdData(oRdData),
    .oRamWriteEnable(oRamWriteEnable),
    .oRamReadAddress(oRamReadAddress),
    .oRamWriteAddress(oRamWriteAddress),
    .oRamDataIn(oRamDataIn),
    .iRamDataOut(ram_q)
  );

  always #5 Clock = ~Clock;

  // RAM with registered read (old data on the read edge)
  logic [DW-1:0] ram [DEPTH];
  always @(posedge Clock) begin
    ram_q <= ram[oRamReadAddress];
    if (oRamWriteEnable) ram[oRamWriteAddress] = oRamDataIn;
  end

  // reference model state
  int            n_cmp = 0;
  int            n_bad = 0;
  bit            last_b;
  int            owner;
  bit            exp_va, exp_vb;
  logic [DW-1:0] exp_da, exp_db;
  logic [DW-1:0] mmem [DEPTH];
  bit            rd_known, wr_known;
  logic [AW-1:0] last_rd, last_wr;
  logic [DW-1:0] last_wd;
  logic          obs_ga, obs_gb, obs_va, obs_vb, obs_we;
  logic [DW-1:0] obs_rd;
  int            cnt_a, cnt_b;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_b   = 1'b1;
    owner    = 0;
    exp_va   = 1'b0;
    exp_vb   = 1'b0;
    rd_known = 1'b0;
    wr_known = 1'b0;
  endtask

  // one clock: check at negedge, advance model, return at posedge+1
  task automatic cycle();
    bit            ea, eb, swe, ewe;
    logic [AW-1:0] ad;
    logic [DW-1:0] dd;
    @(negedge Clock);
    ea = 1'b0;
    eb = 1'b0;
    if (Reset === 1'b1) begin
      if (owner == 1) ea = reqA;
      else if (owner == 2) eb = reqB;
      else if (reqA && reqB) begin
        ea = last_b;
        eb = !last_b;
      end else begin
        ea = reqA;
        eb = reqB;
      end
    end
    obs_ga = oGntA;
    obs_gb = oGntB;
    obs_va = oValidA;
    obs_vb = oValidB;
    obs_we = oRamWriteEnable;
    obs_rd = oRdData;
    cnt_a += int'(oGntA === 1'b1);
    cnt_b += int'(oGntB === 1'b1);
    chk("gnt_a", oGntA, ea);
    chk("gnt_b", oGntB, eb);
    chk("valid_a", oValidA, exp_va);
    chk("valid_b", oValidB, exp_vb);
    if (exp_va) chk("rd_data_a", oRdData, exp_da);
    if (exp_vb) chk("rd_data_b", oRdData, exp_db);
    swe = ea ? weA : (eb ? weB : 1'b0);
    ad  = ea ? addrA : addrB;
    dd  = ea ? dataA : dataB;
    ewe = (ea || eb) && swe;
    chk("ram_we", oRamWriteEnable, ewe);
    if ((ea || eb) && !swe) begin
      chk("rd_addr", oRamReadAddress, ad);
      last_rd  = ad;
      rd_known = 1'b1;
    end else if (rd_known) begin
      chk("rd_addr_hold", oRamReadAddress, last_rd);
    end
    if (ewe) begin
      chk("wr_addr", oRamWriteAddress, ad);
      chk("wr_data", oRamDataIn, dd);
      last_wr  = ad;
      last_wd  = dd;
      wr_known = 1'b1;
    end else if (wr_known) begin
      chk("wr_addr_hold", oRamWriteAddress, last_wr);
      chk("wr_data_hold", oRamDataIn, last_wd);
    end
    exp_va = ea && !weA;
    exp_vb = eb && !weB;
    if (exp_va) exp_da = mmem[addrA];
    if (exp_vb) exp_db = mmem[addrB];
    if (ewe) mmem[ad] = dd;
`ifdef ARB_LOCK_EN
    if (owner == 1) begin
      if (!reqA || (ea && !lockA)) owner = 0;
    end else if (owner == 2) begin
      if (!reqB || (eb && !lockB)) owner = 0;
    end else if (ea && lockA) begin
      owner = 1;
    end else if (eb && lockB) begin
      owner = 2;
    end
`endif
    if (ea) last_b = 1'b0;
    else if (eb) last_b = 1'b1;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]  = 8'(i * 7 + 3);
      mmem[i] = 8'(i * 7 + 3);
    end
    cnt_a = 0;
    cnt_b = 0;
`ifdef ARB_LOCK_EN
    lockA = 1'b0;
    lockB = 1'b0;
`endif
    // reset held low with both requesting: nothing granted
    Reset = 1'b0;
    reqA = 1'b1; weA = 1'b0; addrA = 10'h001; dataA = 8'h00;
    reqB = 1'b1; weB = 1'b0; addrB = 10'h002; dataB = 8'h00;
    model_reset();
    cycle();
    chk("rst_gnt_a", obs_ga, 1'b0);
    chk("rst_we", obs_we, 1'b0);
    cycle();

    // simultaneous reads after reset: A, then B, valids one cycle later
    Reset = 1'b1;
    cycle();
    chk("both_c0_gnt_a", obs_ga, 1'b1);
    reqA = 1'b0;
    cycle();
    chk("both_c1_gnt_b", obs_gb, 1'b1);
    chk("both_c1_valid_a", obs_va, 1'b1);
    reqB = 1'b0;
    cycle();
    chk("both_c2_valid_b", obs_vb, 1'b1);

    // write then read back
    reqA = 1'b1; weA = 1'b1; addrA = 10'h010; dataA = 8'h5A;
    cycle();
    chk("wr_gnt_a", obs_ga, 1'b1);
    weA = 1'b0;
    cycle();
    reqA = 1'b0;
    cycle();
    chk("rb_valid_a", obs_va, 1'b1);
    chk("rb_data", obs_rd, 8'h5A);

    // B alone writes three times: no valid
    reqB = 1'b1; weB = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addrB = 10'(10'h020 + i);
      dataB = 8'(8'hC0 + i);
      cycle();
      chk("bw_gnt_b", obs_gb, 1'b1);
      chk("bw_we", obs_we, 1'b1);
    end
    reqB = 1'b0;
    cycle();
    chk("bw_no_valid", obs_vb, 1'b0);

    // reset right after a B read grant kills its valid
    reqB = 1'b1; weB = 1'b0; addrB = 10'h005;
    cycle();
    reqB = 1'b0;
    Reset = 1'b0;
    model_reset();
    #1;
    chk("rst_kills_valid_b", oValidB, 1'b0);
    cycle();
    Reset = 1'b1;

    // continuous contention: first tie to A, then strict alternation
    reqA = 1'b1; weA = 1'b0; addrA = 10'h003;
    reqB = 1'b1; weB = 1'b0; addrB = 10'h004;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i == 0) chk("tie_after_rst_a", obs_ga, 1'b1);
    end
    chk("rr_cnt_a", cnt_a, 4);
    chk("rr_cnt_b", cnt_b, 4);
    reqA = 1'b0;
    reqB = 1'b0;
    cycle();

`ifdef ARB_LOCK_EN
    // locked read then unlocked write by A holds B off
    Reset = 1'b0;
    model_reset();
    cycle();
    Reset = 1'b1;
    reqA = 1'b1; weA = 1'b0; addrA = 10'h007; lockA = 1'b1;
    reqB = 1'b1; weB = 1'b0; addrB = 10'h008; lockB = 1'b0;
    cycle();
    chk("lk_c0_gnt_a", obs_ga, 1'b1);
    weA = 1'b1; dataA = 8'h33; lockA = 1'b0;
    cycle();
    chk("lk_c1_gnt_a", obs_ga, 1'b1);
    chk("lk_c1_no_b", obs_gb, 1'b0);
    reqA = 1'b0;
    cycle();
    chk("lk_c2_gnt_b", obs_gb, 1'b1);
    reqB = 1'b0;
    cycle();
`endif

    // random traffic, requests held until granted
    for (int i = 0; i < 400; i++) begin
      if (!reqA && $urandom_range(0, 2) != 0) begin
        reqA  = 1'b1;
        weA   = 1'($urandom_range(0, 1));
        addrA = 10'($urandom_range(0, 15));
        dataA = 8'($urandom);
`ifdef ARB_LOCK_EN
        lockA = ($urandom_range(0, 3) == 0);
`endif
      end
      if (!reqB && $urandom_range(0, 2) != 0) begin
        reqB  = 1'b1;
        weB   = 1'($urandom_range(0, 1));
        addrB = 10'($urandom_range(0, 15));
        dataB = 8'($urandom);
`ifdef ARB_LOCK_EN
        lockB = ($urandom_range(0, 3) == 0);
`endif
      end
      cycle();
      if (obs_ga === 1'b1) reqA = 1'b0;
      if (obs_gb === 1'b1) reqB = 1'b0;
    end
    reqA = 1'b0;
    reqB = 1'b0;
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
